// File: rtl/vga_timing_table_if.sv
// Host/config bus and timing-generator handshake for the VGA timing table.
// The master modport is the host side; the table itself connects through slave.
interface vga_timing_table_if #(
   parameter int RES_NUM = 4,
   parameter int H_W     = 12,
   parameter int V_W     = 11,
   parameter int FREQ_W  = 8
);
   localparam int SEL_W = $clog2(RES_NUM);

   logic              req_i;
   logic [SEL_W-1:0]  sel_i;
   logic              stop_i;
   logic              frame_end_i;
   logic              wr_en_i;
   logic [SEL_W-1:0]  wr_idx_i;
   logic [3:0]        wr_field_i;
   logic [15:0]       wr_data_i;

   logic [H_W-1:0]    hd_o;
   logic [H_W-1:0]    hf_o;
   logic [H_W-1:0]    hr_o;
   logic [H_W-1:0]    hb_o;
   logic [V_W-1:0]    vd_o;
   logic [V_W-1:0]    vf_o;
   logic [V_W-1:0]    vr_o;
   logic [V_W-1:0]    vb_o;
   logic [FREQ_W-1:0] freq_int_o;
   logic [FREQ_W-1:0] freq_frac_o;
   logic [SEL_W-1:0]  active_sel_o;
   logic              valid_o;
   logic              busy_o;
   logic              err_o;

   modport master (
      output req_i, sel_i, stop_i, frame_end_i,
      output wr_en_i, wr_idx_i, wr_field_i, wr_data_i,
      input  hd_o, hf_o, hr_o, hb_o, vd_o, vf_o, vr_o, vb_o,
      input  freq_int_o, freq_frac_o, active_sel_o, valid_o, busy_o, err_o
   );

   modport slave (
      input  req_i, sel_i, stop_i, frame_end_i,
      input  wr_en_i, wr_idx_i, wr_field_i, wr_data_i,
      output hd_o, hf_o, hr_o, hb_o, vd_o, vf_o, vr_o, vb_o,
      output freq_int_o, freq_frac_o, active_sel_o, valid_o, busy_o, err_o
   );
endinterface

// File: rtl/vga_timing_table.sv
// Runtime-programmable VGA timing table; a selected entry is copied into shadow
// output registers, and switches while running wait for the next frame boundary.
module vga_timing_table #(
   parameter int RES_NUM = 4,
   parameter int H_W     = 12,
   parameter int V_W     = 11,
   parameter int FREQ_W  = 8
) (
   input logic               clk_i,
   input logic               arstn_i,
   vga_timing_table_if.slave bus
);
   localparam int SEL_W = $clog2(RES_NUM);

   typedef struct packed {
      logic [H_W-1:0]    hd;
      logic [H_W-1:0]    hf;
      logic [H_W-1:0]    hr;
      logic [H_W-1:0]    hb;
      logic [V_W-1:0]    vd;
      logic [V_W-1:0]    vf;
      logic [V_W-1:0]    vr;
      logic [V_W-1:0]    vb;
      logic [FREQ_W-1:0] fint;
      logic [FREQ_W-1:0] ffrac;
   } timing_t;

   // 800x600 @ 40 MHz is the power-up mode, always usable out of reset.
   localparam timing_t RESET_ENTRY = '{
      hd: H_W'(800), hf: H_W'(40), hr: H_W'(128), hb: H_W'(88),
      vd: V_W'(600), vf: V_W'(1),  vr: V_W'(4),   vb: V_W'(23),
      fint: FREQ_W'(40), ffrac: FREQ_W'(0)
   };

   typedef enum logic [1:0] {IDLE, ACTIVE, PENDING} state_t;

   timing_t          tbl_q [RES_NUM];
   timing_t          tbl_d [RES_NUM];
   logic [9:0]       mask_q [RES_NUM];
   logic [9:0]       mask_d [RES_NUM];

   state_t           state_q, state_d;
   logic [SEL_W-1:0] pend_sel_q, pend_sel_d;
   timing_t          act_q, act_d;
   logic [SEL_W-1:0] act_sel_q, act_sel_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;

   logic             req_ok;
   timing_t          req_entry;
   timing_t          pend_entry;

   always_comb begin
      tbl_d  = tbl_q;
      mask_d = mask_q;
      if (bus.wr_en_i) begin
         for (int i = 0; i < RES_NUM; i++) begin
            if (bus.wr_idx_i == SEL_W'(i)) begin
               case (bus.wr_field_i)
                  4'd0: tbl_d[i].hd    = bus.wr_data_i[H_W-1:0];
                  4'd1: tbl_d[i].hf    = bus.wr_data_i[H_W-1:0];
                  4'd2: tbl_d[i].hr    = bus.wr_data_i[H_W-1:0];
                  4'd3: tbl_d[i].hb    = bus.wr_data_i[H_W-1:0];
                  4'd4: tbl_d[i].vd    = bus.wr_data_i[V_W-1:0];
                  4'd5: tbl_d[i].vf    = bus.wr_data_i[V_W-1:0];
                  4'd6: tbl_d[i].vr    = bus.wr_data_i[V_W-1:0];
                  4'd7: tbl_d[i].vb    = bus.wr_data_i[V_W-1:0];
                  4'd8: tbl_d[i].fint  = bus.wr_data_i[FREQ_W-1:0];
                  4'd9: tbl_d[i].ffrac = bus.wr_data_i[FREQ_W-1:0];
                  default: ;
               endcase
               if (bus.wr_field_i <= 4'd9) mask_d[i][bus.wr_field_i] = 1'b1;
            end
         end
      end
   end

   // Lookups read the pre-write table, so a same-cycle load sees the old contents.
   always_comb begin
      req_ok     = 1'b0;
      req_entry  = tbl_q[0];
      pend_entry = tbl_q[0];
      for (int i = 0; i < RES_NUM; i++) begin
         if (bus.sel_i == SEL_W'(i)) begin
            req_ok    = &mask_q[i];
            req_entry = tbl_q[i];
         end
         if (pend_sel_q == SEL_W'(i)) pend_entry = tbl_q[i];
      end
   end

   always_comb begin
      state_d    = state_q;
      pend_sel_d = pend_sel_q;
      act_d      = act_q;
      act_sel_d  = act_sel_q;
      valid_d    = valid_q;
      err_d      = 1'b0;
      if (bus.stop_i) begin
         state_d = IDLE;
         valid_d = 1'b0;
      end else begin
         if (bus.req_i && !req_ok) err_d = 1'b1;
         unique case (state_q)
            IDLE: begin
               if (bus.req_i && req_ok) begin
                  act_d     = req_entry;
                  act_sel_d = bus.sel_i;
                  valid_d   = 1'b1;
                  state_d   = ACTIVE;
               end
            end
            ACTIVE: begin
               if (bus.req_i && req_ok) begin
                  pend_sel_d = bus.sel_i;
                  state_d    = PENDING;
               end
            end
            PENDING: begin
               if (bus.req_i && req_ok && bus.frame_end_i) begin
                  act_d     = req_entry;
                  act_sel_d = bus.sel_i;
                  state_d   = ACTIVE;
               end else if (bus.req_i && req_ok) begin
                  pend_sel_d = bus.sel_i;
               end else if (bus.frame_end_i) begin
                  act_d     = pend_entry;
                  act_sel_d = pend_sel_q;
                  state_d   = ACTIVE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         for (int i = 0; i < RES_NUM; i++) begin
            tbl_q[i]  <= (i == 0) ? RESET_ENTRY : '0;
            mask_q[i] <= (i == 0) ? 10'h3FF : 10'h000;
         end
         state_q    <= IDLE;
         pend_sel_q <= '0;
         act_q      <= RESET_ENTRY;
         act_sel_q  <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         tbl_q      <= tbl_d;
         mask_q     <= mask_d;
         state_q    <= state_d;
         pend_sel_q <= pend_sel_d;
         act_q      <= act_d;
         act_sel_q  <= act_sel_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
      end
   end

   assign bus.hd_o         = act_q.hd;
   assign bus.hf_o         = act_q.hf;
   assign bus.hr_o         = act_q.hr;
   assign bus.hb_o         = act_q.hb;
   assign bus.vd_o         = act_q.vd;
   assign bus.vf_o         = act_q.vf;
   assign bus.vr_o         = act_q.vr;
   assign bus.vb_o         = act_q.vb;
   assign bus.freq_int_o   = act_q.fint;
   assign bus.freq_frac_o  = act_q.ffrac;
   assign bus.active_sel_o = act_sel_q;
   assign bus.valid_o      = valid_q;
   assign bus.busy_o       = (state_q == PENDING);
   assign bus.err_o        = err_q;
endmodule
